// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: FSM states, direction and
// cell codes, and the LFSR tap table.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam logic [2:0] CELL_EMPTY = 3'd0;
   localparam logic [2:0] CELL_UP    = 3'd1;
   localparam logic [2:0] CELL_RIGHT = 3'd2;
   localparam logic [2:0] CELL_DOWN  = 3'd3;
   localparam logic [2:0] CELL_LEFT  = 3'd4;
   localparam logic [2:0] CELL_APPLE = 3'd5;

   // Maximal-length tap masks (bit n-1 set for tap n) for 2..16-bit registers.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      logic [31:0] taps;
      case (width)
         32'd2:   taps = 32'h0000_0003;
         32'd3:   taps = 32'h0000_0006;
         32'd4:   taps = 32'h0000_000C;
         32'd5:   taps = 32'h0000_0014;
         32'd6:   taps = 32'h0000_0030;
         32'd7:   taps = 32'h0000_0060;
         32'd8:   taps = 32'h0000_00B8;
         32'd9:   taps = 32'h0000_0110;
         32'd10:  taps = 32'h0000_0240;
         32'd11:  taps = 32'h0000_0500;
         32'd12:  taps = 32'h0000_0829;
         32'd13:  taps = 32'h0000_100D;
         32'd14:  taps = 32'h0000_2015;
         32'd15:  taps = 32'h0000_6000;
         32'd16:  taps = 32'h0000_D008;
         default: taps = 32'h0000_D008;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running Fibonacci LFSR used as the apple placement seed; resets to 1
// and never reaches the all-zero state.
module snake_lfsr
   import snake_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   always_comb begin
      value_d = {value_q[WIDTH-2:0], ^(value_q & TAPS)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= WIDTH'(1'b1);
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: start/step strobes, direction filtering, score and seed.
// Optional SNAKE_SPEEDUP_EN shortens the step period as apples are eaten.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter logic [7:0]  SIZE_X   = 8'd10,
   parameter logic [7:0]  SIZE_Y   = 8'd10,
   parameter int          SBITS    = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
   parameter logic [23:0] TICK_DIV = 24'd5000000,
   parameter int          SCORE_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_up,
   input  logic               btn_right,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_start,
   input  logic               alive,
   input  logic               apple_eaten,
   output logic               start,
   output logic               step,
   output logic [1:0]         snake_dir,
   output logic [SBITS-1:0]   seed,
   output logic [SCORE_W-1:0] score,
   output logic               game_over
);

   state_e               state_q, state_d;
   logic                 btn_prev_q;
   logic [23:0]          cnt_q, cnt_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [1:0]           dir_q, dir_d;
   logic [1:0]           committed_q, committed_d;
   logic [1:0]           req_q, req_d;
   logic [1:0]           req_s;
   logic [1:0]           commit_eff_s;
   logic [23:0]          period_s;
   logic                 tick_end_s;
   logic                 start_edge_s;
   logic                 start_s;
   logic                 step_s;

   snake_lfsr #(.WIDTH(SBITS)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (seed)
   );

`ifdef SNAKE_SPEEDUP_EN
   localparam logic [23:0] PER_DEC = TICK_DIV >> 4;
   localparam logic [23:0] PER_MIN = ((TICK_DIV >> 2) == 24'd0) ? 24'd1 : (TICK_DIV >> 2);

   logic [23:0] period_q, period_d;

   always_comb begin
      period_d = period_q;
      if (state_q == ST_INIT) begin
         period_d = TICK_DIV;
      end else if (state_q == ST_RUN && apple_eaten) begin
         period_d = (period_q >= PER_MIN + PER_DEC) ? period_q - PER_DEC : PER_MIN;
      end else begin
         period_d = period_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= TICK_DIV;
      end else begin
         period_q <= period_d;
      end
   end

   assign period_s = period_q;
`else
   assign period_s = TICK_DIV;
`endif

   assign tick_end_s   = (cnt_q >= period_s - 24'd1);
   assign start_edge_s = btn_start & ~btn_prev_q;

   always_comb begin
      if (btn_up) begin
         req_s = DIR_UP;
      end else if (btn_right) begin
         req_s = DIR_RIGHT;
      end else if (btn_down) begin
         req_s = DIR_DOWN;
      end else if (btn_left) begin
         req_s = DIR_LEFT;
      end else begin
         req_s = req_q;
      end
   end

   // In the step cycle the reversal check uses the direction being committed now.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      score_d      = score_q;
      dir_d        = dir_q;
      committed_d  = committed_q;
      req_d        = req_s;
      commit_eff_s = committed_q;
      start_s      = 1'b0;
      step_s       = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_edge_s) begin
               state_d     = ST_INIT;
               cnt_d       = 24'd0;
               score_d     = '0;
               dir_d       = DIR_RIGHT;
               committed_d = DIR_RIGHT;
               req_d       = DIR_RIGHT;
            end else begin
               state_d = state_q;
            end
         end
         ST_INIT: begin
            start_s     = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 24'd0;
            score_d     = '0;
            dir_d       = DIR_RIGHT;
            committed_d = DIR_RIGHT;
            req_d       = DIR_RIGHT;
         end
         ST_RUN: begin
            if (apple_eaten && (score_q != '1)) begin
               score_d = score_q + SCORE_W'(1);
            end else begin
               score_d = score_q;
            end
            if (tick_end_s) begin
               cnt_d = 24'd0;
               if (alive) begin
                  step_s       = 1'b1;
                  committed_d  = dir_q;
                  commit_eff_s = dir_q;
               end else begin
                  state_d = ST_OVER;
               end
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
            if (req_s != (commit_eff_s ^ DIR_DOWN)) begin
               dir_d = req_s;
            end else begin
               dir_d = dir_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Game state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         btn_prev_q  <= 1'b0;
         cnt_q       <= 24'd0;
         score_q     <= '0;
         dir_q       <= DIR_RIGHT;
         committed_q <= DIR_RIGHT;
         req_q       <= DIR_RIGHT;
      end else begin
         state_q     <= state_d;
         btn_prev_q  <= btn_start;
         cnt_q       <= cnt_d;
         score_q     <= score_d;
         dir_q       <= dir_d;
         committed_q <= committed_d;
         req_q       <= req_d;
      end
   end

   assign start     = start_s;
   assign step      = step_s;
   assign snake_dir = dir_q;
   assign score     = score_q;
   assign game_over = (state_q == ST_OVER);

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter SIZE_X, default 8'd10, field width in cells.
REQ-002 SHALL have parameter SIZE_Y, default 8'd10, field height in cells.
REQ-003 SHALL have parameter SBITS, default $clog2(SIZE_X*SIZE_Y), seed width.
REQ-004 SHALL have parameter TICK_DIV, default 24'd5000000, clocks per game step.
REQ-005 SHALL have parameter SCORE_W, default 8, score width.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports btn_up/btn_right/btn_down/btn_left, input, 1 each, direction buttons, level, already synchronous to clk.
REQ-009 SHALL have port btn_start, input, 1, start/restart button, level, synchronous.
REQ-010 SHALL have port alive, input, 1, field reports the next move is legal.
REQ-011 SHALL have port apple_eaten, input, 1, one-cycle pulse from field on growth.
REQ-012 SHALL have port start, output, 1, field initialise strobe.
REQ-013 SHALL have port step, output, 1, field advance strobe.
REQ-014 SHALL have port snake_dir, output, 2, 0 up, 1 right, 2 down, 3 left.
REQ-015 SHALL have port seed, output, SBITS, apple placement seed.
REQ-016 SHALL have ports score (output, SCORE_W) and game_over (output, 1).

Function
REQ-017 SHALL implement FSM IDLE -> INIT -> RUN -> OVER -> INIT.
REQ-018 IDLE/OVER: rising edge of btn_start (registered previous value) SHALL move to INIT next cycle.
REQ-019 INIT: start SHALL be 1 for exactly one cycle; score cleared; snake_dir set to 1; tick counter cleared; next state RUN.
REQ-020 RUN: tick counter counts 0..TICK_DIV-1 and wraps; step SHALL be 1 for the single cycle when counter equals TICK_DIV-1 and alive=1.
REQ-021 RUN: counter at TICK_DIV-1 with alive=0 SHALL produce no step and move to OVER next cycle; game_over=1 exactly while in OVER.
REQ-022 start and step SHALL never be 1 in the same cycle; step SHALL be 0 outside RUN.
REQ-023 Direction request: one button high selects its code; several high SHALL resolve priority up > right > down > left; none high keeps previous request.
REQ-024 A request equal to committed_dir XOR 2 (reversal) SHALL be ignored; committed_dir is snake_dir sampled at the last step (1 after INIT).
REQ-025 snake_dir SHALL update one cycle after a valid button press, during RUN only, and remain stable in the step cycle.
REQ-026 seed SHALL be an SBITS-bit maximal-length Fibonacci LFSR advancing every cycle in all states, never all-zero.
REQ-027 score SHALL increment on apple_eaten during RUN, saturate at all-ones, ignore apple_eaten in other states.
REQ-028 btn_start held high SHALL restart only once (edge, not level).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, start=0, step=0, snake_dir=1, seed=1, score=0, game_over=0, tick counter 0, edge register 0.
REQ-030 rst mid-RUN SHALL abort immediately; no step or start until a new btn_start edge after rst deasserts.

Configuration
REQ-031 Macro SNAKE_SPEEDUP_EN defined: step period SHALL start at TICK_DIV, shrink by TICK_DIV/16 per apple_eaten, floor TICK_DIV/4, reload to TICK_DIV in INIT.
REQ-032 Macro undefined: step period SHALL be constant TICK_DIV; no period register synthesised.

Structure
REQ-033 Package snake_pkg SHALL hold state encoding, direction codes DIR_UP..DIR_LEFT, cell codes (empty, four snake directions, apple 3'd5).
REQ-034 LFSR SHALL be sub-module snake_lfsr (parameter width, ports clk, rst, value); all else in snake_game_ctrl.

Verification (TICK_DIV=4, SBITS=7)
REQ-035 rst, btn_start 0->1 -> start=1 at one cycle, first step 4 cycles later, steps every 4 cycles, snake_dir=1.
REQ-036 RUN, committed_dir=1, btn_left pulse -> snake_dir stays 1; btn_up pulse -> snake_dir=0 next cycle.
REQ-037 btn_up and btn_down together, committed_dir=1 -> snake_dir=0.
REQ-038 alive=0 at counter 3 -> no step, game_over=1 next cycle; btn_start edge -> start pulse, score=0, game_over=0.
REQ-039 SCORE_W=2, 5 apple_eaten pulses in RUN -> score=3; pulse in OVER -> unchanged.
REQ-040 rst asserted mid-RUN between clock edges -> outputs at reset values before next edge; seed sequence never 0 over 127 cycles.
